board_io_ctrl: RTL and testbench

Parametrised board I/O front end for the Mini SRC FPGA top level, replacing the per-signal glue between the DE-board pins and the DataPath/Control blocks. It synchronises and debounces NUM_KEYS push-buttons with a configurable stability window and emits one-cycle press pulses. It synchronises NUM_SW slide switches onto a zero-extended DATA_W in-port bus. It registers the DataPath out-port into a freezable display latch that drives NUM_HEX seven-segment digits.

---
 rtl/board_io_ctrl_if.sv | 27 ++
 rtl/board_io_ctrl.sv | 108 ++++++++++
 tb/tb_board_io_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/board_io_ctrl_if.sv
// Board I/O bundle between the DE-board pins, the DataPath in/out ports and board_io_ctrl.
// The master side drives the raw pins and the out-port. The slave side is the controller.
interface board_io_ctrl_if #(
  parameter int unsigned NUM_KEYS = 2,
  parameter int unsigned NUM_SW   = 8,
  parameter int unsigned NUM_HEX  = 2,
  parameter int unsigned DATA_W   = 32
);
  logic [NUM_KEYS-1:0]  KEY;
  logic [NUM_SW-1:0]    SW;
  logic [DATA_W-1:0]    OUTPORTout;
  logic                 freeze;
  logic [NUM_KEYS-1:0]  key_level;
  logic [NUM_KEYS-1:0]  key_press;
  logic [DATA_W-1:0]    INPORTin;
  logic [7*NUM_HEX-1:0] HEX;

  modport master (
    output KEY, SW, OUTPORTout, freeze,
    input  key_level, key_press, INPORTin, HEX
  );

  modport slave (
    input  KEY, SW, OUTPORTout, freeze,
    output key_level, key_press, INPORTin, HEX
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O front end: key synchronise/debounce with press pulses,
// switch synchroniser onto the in-port, and a freezable seven-segment display latch.
module board_io_ctrl #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned NUM_SW          = 8,
  parameter int unsigned NUM_HEX         = 2,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  board_io_ctrl_if.slave     io
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DISP_W = 4 * NUM_HEX;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] key_meta_q,  key_meta_d;
  logic [NUM_KEYS-1:0] key_sync_q,  key_sync_d;
  logic [NUM_KEYS-1:0] key_level_q, key_level_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_SW-1:0]   sw_meta_q,   sw_meta_d;
  logic [NUM_SW-1:0]   sw_sync_q,   sw_sync_d;
  logic [DISP_W-1:0]   disp_q,      disp_d;

  always_comb begin
    key_meta_d  = ~io.KEY;
    key_sync_d  = key_meta_q;
    key_level_d = key_level_q;
    key_press_d = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (key_sync_q[k] == key_level_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        // Accept the change; only a rising accept produces a press pulse.
        key_level_d[k] = key_sync_q[k];
        key_press_d[k] = key_sync_q[k];
        cnt_d[k]       = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end

    sw_meta_d = io.SW;
    sw_sync_d = sw_meta_q;

    disp_d = io.freeze ? disp_q : io.OUTPORTout[DISP_W-1:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_meta_q  <= '0;
      key_sync_q  <= '0;
      key_level_q <= '0;
      key_press_q <= '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      disp_q      <= '0;
    end else begin
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      key_level_q <= key_level_d;
      key_press_q <= key_press_d;
      for (int unsigned k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      disp_q      <= disp_d;
    end
  end

  always_comb begin
    io.INPORTin               = '0;
    io.INPORTin[NUM_SW-1:0]   = sw_sync_q;
  end

  assign io.key_level = key_level_q;
  assign io.key_press = key_press_q;

  always_comb begin
    io.HEX = '1;
    for (int unsigned i = 0; i < NUM_HEX; i++) begin
      case (disp_q[4*i +: 4])
        4'h0: io.HEX[7*i +: 7] = 7'b1000000;
        4'h1: io.HEX[7*i +: 7] = 7'b1111001;
        4'h2: io.HEX[7*i +: 7] = 7'b0100100;
        4'h3: io.HEX[7*i +: 7] = 7'b0110000;
        4'h4: io.HEX[7*i +: 7] = 7'b0011001;
        4'h5: io.HEX[7*i +: 7] = 7'b0010010;
        4'h6: io.HEX[7*i +: 7] = 7'b0000010;
        4'h7: io.HEX[7*i +: 7] = 7'b1111000;
        4'h8: io.HEX[7*i +: 7] = 7'b0000000;
        4'h9: io.HEX[7*i +: 7] = 7'b0010000;
        4'hA: io.HEX[7*i +: 7] = 7'b0001000;
        4'hB: io.HEX[7*i +: 7] = 7'b0000011;
        4'hC: io.HEX[7*i +: 7] = 7'b1000110;
        4'hD: io.HEX[7*i +: 7] = 7'b0100001;
        4'hE: io.HEX[7*i +: 7] = 7'b0000110;
        default: io.HEX[7*i +: 7] = 7'b0001110;
      endcase
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with DEBOUNCE_CYCLES=4 (key accept 6 cycles after the pin edge).
module tb_board_io_ctrl;

  localparam int unsigned NUM_KEYS = 2;
  localparam int unsigned NUM_SW   = 8;
  localparam int unsigned NUM_HEX  = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEB      = 4;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_F = 7'b0001110;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   hits;

  always #5 clk = ~clk;

  board_io_ctrl_if #(
    .NUM_KEYS(NUM_KEYS), .NUM_SW(NUM_SW), .NUM_HEX(NUM_HEX), .DATA_W(DATA_W)
  ) io ();

  board_io_ctrl #(
    .NUM_KEYS(NUM_KEYS), .NUM_SW(NUM_SW), .NUM_HEX(NUM_HEX),
    .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .io       (io.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst           = 1'b1;
    io.KEY        = 2'b11;
    io.SW         = '0;
    io.OUTPORTout = '0;
    io.freeze     = 1'b0;
    #1;
    tick(3);
    check("rst_level", 32'(io.key_level), 32'h0);
    check("rst_press", 32'(io.key_press), 32'h0);
    check("rst_inport", io.INPORTin, 32'h0);
    check("rst_hex", 32'(io.HEX), 32'({SEG_0, SEG_0}));

    rst = 1'b0;
    tick(2);

    // Clean press on KEY[0]
    io.KEY = 2'b10;
    tick(5);
    check("press0_early", 32'(io.key_level), 32'h0);
    tick(1);
    check("press0_level", 32'(io.key_level), 32'h1);
    check("press0_pulse", 32'(io.key_press), 32'h1);
    tick(1);
    check("press0_pulse_end", 32'(io.key_press), 32'h0);
    hits = 0;
    repeat (13) begin
      tick(1);
      if (io.key_press != 2'b00) hits++;
    end
    check("press0_hold_nopulse", 32'(hits), 32'h0);
    check("press0_hold_level", 32'(io.key_level), 32'h1);

    // Release KEY[0]
    io.KEY = 2'b11;
    hits = 0;
    repeat (5) begin
      tick(1);
      if (io.key_press != 2'b00) hits++;
    end
    check("rel0_early", 32'(io.key_level), 32'h1);
    tick(1);
    if (io.key_press != 2'b00) hits++;
    check("rel0_level", 32'(io.key_level), 32'h0);
    check("rel0_nopulse", 32'(hits), 32'h0);
    tick(2);

    // Bounce on KEY[1]: low 3, high 1, low 3, high
    hits = 0;
    io.KEY = 2'b01; repeat (3) begin tick(1); if (io.key_level != 2'b00 || io.key_press != 2'b00) hits++; end
    io.KEY = 2'b11; repeat (1) begin tick(1); if (io.key_level != 2'b00 || io.key_press != 2'b00) hits++; end
    io.KEY = 2'b01; repeat (3) begin tick(1); if (io.key_level != 2'b00 || io.key_press != 2'b00) hits++; end
    io.KEY = 2'b11; repeat (8) begin tick(1); if (io.key_level != 2'b00 || io.key_press != 2'b00) hits++; end
    check("bounce_reject", 32'(hits), 32'h0);

    // Solid press on KEY[1] for 10 cycles: one pulse
    io.KEY = 2'b01;
    hits = 0;
    repeat (10) begin
      tick(1);
      if (io.key_press == 2'b10) hits++;
      else if (io.key_press != 2'b00) hits += 100;
    end
    check("key1_one_pulse", 32'(hits), 32'h1);
    check("key1_level", 32'(io.key_level), 32'h2);
    io.KEY = 2'b11;
    tick(8);
    check("key1_released", 32'(io.key_level), 32'h0);

    // Simultaneous presses on both keys
    io.KEY = 2'b00;
    tick(6);
    check("both_pulse", 32'(io.key_press), 32'h3);
    io.KEY = 2'b11;
    tick(8);

    // Switches: 2-cycle latency, zero-extended
    io.SW = 8'hC0;
    tick(1);
    check("sw_c0_1cyc", io.INPORTin, 32'h0);
    tick(1);
    check("sw_c0", io.INPORTin, 32'h000000C0);
    io.SW = 8'h05;
    tick(1);
    check("sw_05_1cyc", io.INPORTin, 32'h000000C0);
    tick(1);
    check("sw_05", io.INPORTin, 32'h00000005);

    // Display latch and freeze
    io.OUTPORTout = 32'h0000003A;
    tick(1);
    check("hex_3a", 32'(io.HEX), 32'({SEG_3, SEG_A}));
    io.freeze     = 1'b1;
    io.OUTPORTout = 32'h000000FF;
    tick(2);
    check("hex_frozen", 32'(io.HEX), 32'({SEG_3, SEG_A}));
    io.freeze = 1'b0;
    tick(1);
    check("hex_ff", 32'(io.HEX), 32'({SEG_F, SEG_F}));
    io.OUTPORTout = 32'hABCD0012;
    tick(1);
    check("hex_upper_ignored", 32'(io.HEX), 32'({SEG_1, SEG_2}));

    // Reset during a press at cnt=2, key held through release
    io.KEY = 2'b10;
    tick(4);
    rst = 1'b1;
    io.freeze = 1'b1;
    hits = 0;
    repeat (2) begin
      tick(1);
      if (io.key_press != 2'b00 || io.key_level != 2'b00) hits++;
    end
    check("rst_mid_quiet", 32'(hits), 32'h0);
    check("rst_over_freeze", 32'(io.HEX), 32'({SEG_0, SEG_0}));
    rst = 1'b0;
    io.freeze = 1'b0;
    hits = 0;
    repeat (5) begin
      tick(1);
      if (io.key_press != 2'b00) hits++;
    end
    check("post_rst_nopulse", 32'(hits), 32'h0);
    tick(1);
    check("post_rst_pulse", 32'(io.key_press), 32'h1);
    tick(1);
    check("post_rst_pulse_end", 32'(io.key_press), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
